ita_scroll_text: RTL



---
 rtl/ita_scroll_text_if.sv | 43 ++++
 rtl/ita_scroll_text.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ita_scroll_text_if.sv
// Bus bundle for ita_scroll_text (writes, window control, scan readout).
// scroll_dir exists only when ITA_SCROLL_DIR_EN is defined.
interface ita_scroll_text_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [5:0]  wr_data;
  logic [5:0]  msg_len;
  logic        scroll_en;
  logic [3:0]  digit_idx;
  logic [13:0] segm;
  logic        wrap;
`ifdef ITA_SCROLL_DIR_EN
  logic        scroll_dir;

  modport master (
    output wr_en, wr_addr, wr_data,
    output msg_len, scroll_en,
    output digit_idx, scroll_dir,
    input  segm, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  msg_len, scroll_en,
    input  digit_idx, scroll_dir,
    output segm, wrap
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data,
    output msg_len, scroll_en,
    output digit_idx,
    input  segm, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  msg_len, scroll_en,
    input  digit_idx,
    output segm, wrap
  );
`endif
endinterface

// File: rtl/ita_scroll_text.sv
// Scrolling message source for the 12-digit 14-segment display mux.
// Define ITA_SCROLL_DIR_EN to add reverse scrolling via scroll_dir.
module ita_scroll_text #(
  parameter int MSG_DEPTH = 32,
  parameter int DIGITS    = 12,
  parameter int TICK_DIV  = 1000000
) (
  input logic              clk,
  input logic              rst_n,
  ita_scroll_text_if.slave bus
);

  localparam int AW =
    (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [6:0] DEPTH7 = 7'(MSG_DEPTH);
  localparam logic [6:0] DIG7   = 7'(DIGITS);
  localparam logic [TW-1:0] TLAST =
    TW'(TICK_DIV - 1);

  logic [5:0]    mem [MSG_DEPTH];
  logic [TW-1:0] tick_cnt;
  logic [6:0]    offset;
  logic [13:0]   segm_q;
  logic          wrap_q;

  logic [6:0]    len;
  logic [6:0]    per;
  logic [6:0]    p_raw;
  logic [6:0]    p;
  logic [5:0]    ch;
  logic          tick;
  logic          len_zero;
  logic          blank;
  logic          rev;
  logic [6:0]    off_nxt;
  logic          wrap_nxt;
  logic [13:0]   seg_nxt;

`ifdef ITA_SCROLL_DIR_EN
  assign rev = bus.scroll_dir;
`else
  assign rev = 1'b0;
`endif

  function automatic logic [13:0] enc(
    input logic [5:0] c
  );
    logic [13:0] s;
    unique case (c)
      6'd1:  s = 14'b11101111000000;
      6'd2:  s = 14'b11110001010010;
      6'd3:  s = 14'b10011100000000;
      6'd4:  s = 14'b11110000010010;
      6'd5:  s = 14'b10011110000000;
      6'd6:  s = 14'b10001110000000;
      6'd7:  s = 14'b10111101000000;
      6'd8:  s = 14'b01101111000000;
      6'd9:  s = 14'b10010000010010;
      6'd10: s = 14'b01111000000000;
      6'd11: s = 14'b00001110001100;
      6'd12: s = 14'b00011100000000;
      6'd13: s = 14'b01101100101000;
      6'd14: s = 14'b01101100100100;
      6'd15: s = 14'b11111100000000;
      6'd16: s = 14'b11001111000000;
      6'd17: s = 14'b11111100000100;
      6'd18: s = 14'b11001111000100;
      6'd19: s = 14'b10110111000000;
      6'd20: s = 14'b10000000010010;
      6'd21: s = 14'b01111100000000;
      6'd22: s = 14'b00001100001001;
      6'd23: s = 14'b01101100000101;
      6'd24: s = 14'b00000000101101;
      6'd25: s = 14'b00000000101010;
      6'd26: s = 14'b10010000001001;
      6'd27: s = 14'b11111100001001;
      6'd28: s = 14'b01100000001000;
      6'd29: s = 14'b11011011000000;
      6'd30: s = 14'b11110001000000;
      6'd31: s = 14'b01100111000000;
      6'd32: s = 14'b10110111000000;
      6'd33: s = 14'b10111111000000;
      6'd34: s = 14'b11100000000000;
      6'd35: s = 14'b11111111000000;
      6'd36: s = 14'b11110111000000;
      default: s = 14'b0;
    endcase
    return s;
  endfunction

  always_comb begin
    len = {1'b0, bus.msg_len};
    if (len > DEPTH7) len = DEPTH7;
    per      = len + DIG7;
    len_zero = (len == 7'd0);
    tick     = bus.scroll_en &&
               (tick_cnt == TLAST);
  end

  // Window position in the virtual message
  // (buffer chars, then DIGITS blanks).
  always_comb begin
    p_raw = offset + {3'b0, bus.digit_idx};
    p     = p_raw;
    if (p_raw >= per) p = p_raw - per;
    ch    = mem[p[AW-1:0]];
    blank = ({3'b0, bus.digit_idx} >= DIG7) ||
            len_zero || (p >= len);
    seg_nxt = blank ? 14'b0 : enc(ch);
  end

  // A shrunken message resets the window
  // silently, ahead of any tick.
  always_comb begin
    off_nxt  = offset;
    wrap_nxt = 1'b0;
    if (len_zero || offset >= per) begin
      off_nxt = 7'd0;
    end else if (tick) begin
      if (rev) begin
        wrap_nxt = (offset == 7'd0);
        off_nxt  = (offset == 7'd0) ?
                   per - 7'd1 : offset - 7'd1;
      end else begin
        wrap_nxt = (offset == per - 7'd1);
        off_nxt  = (offset == per - 7'd1) ?
                   7'd0 : offset + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_DEPTH; i++)
        mem[i] <= '0;
    end else if (bus.wr_en &&
      ({1'b0, bus.wr_addr} < 6'(MSG_DEPTH))) begin
      mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (bus.scroll_en) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
      wrap_q <= 1'b0;
      segm_q <= '0;
    end else begin
      offset <= off_nxt;
      wrap_q <= wrap_nxt;
      segm_q <= seg_nxt;
    end
  end

  assign bus.segm = segm_q;
  assign bus.wrap = wrap_q;

endmodule
